// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the scheduled console UART transmitter.
package uart_sched_pkg;

  // Line FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // Bit periods per frame: start + data + stop.
  localparam int unsigned FRAME_BITS = 10;
  // Payload bits per frame.
  localparam int unsigned DATA_BITS  = 8;
  // Width of the data-bit index.
  localparam int unsigned BIT_IDX_W  = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_sched_fifo.sv
// Per-requester synchronous FIFO.
// Ports: clk/rst (async active-high), push/din write side (push ignored when
// full), pop/dout read side (dout shows the head, pop ignored when empty),
// full/empty registered status flags.
module uart_sched_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Pointer/count update; a simultaneous push and pop leaves the count alone.
  always_comb begin
    push_ok  = push & ~full_q;
    pop_ok   = pop & ~empty_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: empty/full gate every read and write.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Shared console transmitter: two requester FIFOs, round-robin frame
// scheduler and a clocked serial line (UART_tx data, UART_clk bit strobe).
// Ports: clk, rst (async active-high); wr0/din0/rdy0 and wr1/din1/rdy1
// requester write sides; busy (frame active or data queued); gnt (requester
// of the current/last frame); UART_tx (idle 1); UART_clk (rises mid-bit).
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned DIV   = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr0,
  input  logic [DATA_BITS-1:0] din0,
  output logic                 rdy0,
  input  logic                 wr1,
  input  logic [DATA_BITS-1:0] din1,
  output logic                 rdy1,
  output logic                 busy,
  output logic                 gnt,
  output logic                 UART_tx,
  output logic                 UART_clk
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   gnt_q, gnt_d;
  logic                   ptr_q, ptr_d;
  logic                   tx_q, tx_d;
  logic                   uclk_q, uclk_d;
  logic                   busy_q, busy_d;

  logic                   pop0, pop1;
  logic                   full0, full1;
  logic                   empty0, empty1;
  logic [DATA_BITS-1:0]   dout0, dout1;
  logic                   any_req, sel, launch, period_end;

  uart_sched_fifo #(.DEPTH(DEPTH), .W(DATA_BITS)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (wr0),
    .din   (din0),
    .pop   (pop0),
    .dout  (dout0),
    .full  (full0),
    .empty (empty0)
  );

  uart_sched_fifo #(.DEPTH(DEPTH), .W(DATA_BITS)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (wr1),
    .din   (din1),
    .pop   (pop1),
    .dout  (dout1),
    .full  (full1),
    .empty (empty1)
  );

  // Next-state, arbitration and line-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    tx_d    = tx_q;
    pop0    = 1'b0;
    pop1    = 1'b0;
    launch  = 1'b0;

    any_req    = ~empty0 | ~empty1;
    // Pointer breaks ties; otherwise the only non-empty FIFO wins.
    sel        = (~empty0 & ~empty1) ? ptr_q : empty0;
    period_end = (cnt_q == CNT_LAST);

    if (state_q != ST_IDLE) begin
      cnt_d = period_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          launch = 1'b1;
        end
      end
      ST_START: begin
        if (period_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = sh_q[0];
          sh_d    = {1'b0, sh_q[DATA_BITS-1:1]};
        end
      end
      ST_DATA: begin
        if (period_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + BIT_IDX_W'(1);
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[DATA_BITS-1:1]};
          end
        end
      end
      ST_STOP: begin
        if (period_end) begin
          // Chain straight into the next frame when anything is queued.
          if (any_req) begin
            launch = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Grant: pop the winner into the shifter and start the frame.
    if (launch) begin
      state_d = ST_START;
      cnt_d   = '0;
      tx_d    = 1'b0;
      pop0    = ~sel;
      pop1    = sel;
      sh_d    = sel ? dout1 : dout0;
      gnt_d   = sel;
      ptr_d   = ~sel;
    end

    // Strobe is high during the second half of every bit period.
    uclk_d = (state_d != ST_IDLE) && (cnt_d >= CNT_HALF);
    // Queued data next cycle is known from this cycle's accepted writes.
    busy_d = (state_d != ST_IDLE) | (wr0 & ~full0) | (wr1 & ~full1)
           | ~empty0 | ~empty1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b0;
      tx_q    <= 1'b1;
      uclk_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      tx_q    <= tx_d;
      uclk_q  <= uclk_d;
      busy_q  <= busy_d;
    end
  end

  assign rdy0     = ~full0;
  assign rdy1     = ~full1;
  assign busy     = busy_q;
  assign gnt      = gnt_q;
  assign UART_tx  = tx_q;
  assign UART_clk = uclk_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a DIV=8 instance for the main
// scenarios and a DIV=2 instance for the chained-frame case.
module tb_uart_tx_sched;

  localparam int FBITS = int'(uart_sched_pkg::FRAME_BITS);
  localparam int DIV_A = 8;
  localparam int DIV_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Instance A (DIV=8)
  logic       rst, wr0, wr1;
  logic [7:0] din0, din1;
  logic       rdy0, rdy1, busy, gnt, uart_tx, uart_clk;

  uart_tx_sched #(.DIV(DIV_A), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wr0(wr0), .din0(din0), .rdy0(rdy0),
    .wr1(wr1), .din1(din1), .rdy1(rdy1),
    .busy(busy), .gnt(gnt), .UART_tx(uart_tx), .UART_clk(uart_clk)
  );

  // Instance B (DIV=2)
  logic       rst2, wr0_b, wr1_b;
  logic [7:0] din0_b, din1_b;
  logic       rdy0_b, rdy1_b, busy_b, gnt_b, tx_b, uclk_b;

  uart_tx_sched #(.DIV(DIV_B), .DEPTH(4)) dut2 (
    .clk(clk), .rst(rst2),
    .wr0(wr0_b), .din0(din0_b), .rdy0(rdy0_b),
    .wr1(wr1_b), .din1(din1_b), .rdy1(rdy1_b),
    .busy(busy_b), .gnt(gnt_b), .UART_tx(tx_b), .UART_clk(uclk_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard for instance A: expected grant order plus per-requester bytes.
  logic [7:0] exp_b0[$];
  logic [7:0] exp_b1[$];
  logic       exp_g[$];

  int         nbits = 0;
  int         frames = 0;
  int         rises = 0;
  logic [9:0] fr;
  logic [9:0] fr_last;
  logic       fg;

  task automatic score(input logic [9:0] f, input logic g_act);
    logic       g;
    logic [7:0] eb;
    if (exp_g.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_frame: got frame %03h gnt %0d, none expected", f, g_act);
    end else begin
      g = exp_g.pop_front();
      chk("frame_gnt", 32'(g_act), 32'(g));
      chk("start_bit", 32'(f[0]), 32'd0);
      chk("stop_bit", 32'(f[9]), 32'd1);
      if ((g ? exp_b1.size() : exp_b0.size()) == 0) begin
        checks++; errors++;
        $display("FAIL frame_data: got %02h, no byte expected for requester %0d", f[8:1], g);
      end else begin
        eb = g ? exp_b1.pop_front() : exp_b0.pop_front();
        chk("frame_data", 32'(f[8:1]), 32'(eb));
      end
    end
  endtask

  // Console receiver model for instance A: sample on UART_clk rising edge.
  always @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      nbits = 0;
    end else begin
      rises++;
      if (nbits == 0) fg = gnt;
      fr[nbits] = uart_tx;
      nbits++;
      if (nbits == FBITS) begin
        nbits = 0;
        frames++;
        fr_last = fr;
        score(fr, fg);
      end
    end
  end

  // Receiver for instance B: frame start cycles plus byte scoreboard.
  logic [7:0] exp2[$];
  int         rx_t[$];
  int         n2 = 0;
  int         st2 = 0;
  logic [9:0] f2;

  always @(posedge uclk_b or posedge rst2) begin
    if (rst2) begin
      n2 = 0;
    end else begin
      if (n2 == 0) st2 = cyc;
      f2[n2] = tx_b;
      n2++;
      if (n2 == FBITS) begin
        n2 = 0;
        rx_t.push_back(st2);
        chk("b_framing", {30'd0, f2[9], f2[0]}, 32'd2);
        if (exp2.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_frame: got %02h", f2[8:1]);
        end else begin
          chk("b_frame_data", 32'(f2[8:1]), 32'(exp2.pop_front()));
        end
      end
    end
  end

  task automatic wr_one(input logic req, input logic [7:0] d);
    @(negedge clk);
    if (req) begin wr1 = 1'b1; din1 = d; end
    else     begin wr0 = 1'b1; din0 = d; end
    @(negedge clk);
    wr0 = 1'b0;
    wr1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_g.delete();
    exp_b0.delete();
    exp_b1.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  task automatic chk_drained(input string name);
    chk(name, 32'(exp_g.size() + exp_b0.size() + exp_b1.size()), 32'd0);
  endtask

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic [9:0] exp_frame;
    logic       exp_gnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0;
    rst = 1'b1; rst2 = 1'b1;
    wr0 = 1'b0; wr1 = 1'b0; din0 = '0; din1 = '0;
    wr0_b = 1'b0; wr1_b = 1'b0; din0_b = '0; din1_b = '0;

    vecs[0] = '{1'b0, 8'h48, {1'b1, 8'h48, 1'b0}, 1'b0};
    vecs[1] = '{1'b1, 8'h00, {1'b1, 8'h00, 1'b0}, 1'b1};
    vecs[2] = '{1'b0, 8'hFF, {1'b1, 8'hFF, 1'b0}, 1'b0};
    vecs[3] = '{1'b1, 8'hA5, {1'b1, 8'hA5, 1'b0}, 1'b1};
    vecs[4] = '{1'b0, 8'h01, {1'b1, 8'h01, 1'b0}, 1'b0};
    vecs[5] = '{1'b1, 8'h80, {1'b1, 8'h80, 1'b0}, 1'b1};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;

    // Reset state
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_uclk", 32'(uart_clk), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rdy", {30'd0, rdy1, rdy0}, 32'd3);

    // Single frames from a table: latency, framing, busy fall, strobe count
    foreach (vecs[i]) begin
      r0 = rises; f0 = frames;
      exp_g.push_back(vecs[i].req);
      if (vecs[i].req) exp_b1.push_back(vecs[i].data);
      else             exp_b0.push_back(vecs[i].data);
      wr_one(vecs[i].req, vecs[i].data);
      chk("vec_tx_t1", 32'(uart_tx), 32'd1);
      chk("vec_busy_t1", 32'(busy), 32'd1);
      @(negedge clk);
      chk("vec_tx_t2", 32'(uart_tx), 32'd0);
      chk("vec_gnt", 32'(gnt), 32'(vecs[i].exp_gnt));
      repeat (DIV_A * FBITS - 1) @(negedge clk);
      chk("vec_busy_last", 32'(busy), 32'd1);
      @(negedge clk);
      chk("vec_busy_end", 32'(busy), 32'd0);
      chk("vec_rises", 32'(rises - r0), 32'(FBITS));
      chk("vec_frames", 32'(frames - f0), 32'd1);
      chk("vec_frame_bits", 32'(fr_last), 32'(vecs[i].exp_frame));
    end

    // Simultaneous writes: 0x41 then 0x42 back-to-back, 20*DIV cycles
    do_reset();
    r0 = rises;
    exp_g.push_back(1'b0); exp_g.push_back(1'b1);
    exp_b0.push_back(8'h41); exp_b1.push_back(8'h42);
    @(negedge clk);
    wr0 = 1'b1; din0 = 8'h41; wr1 = 1'b1; din1 = 8'h42;
    @(negedge clk);
    wr0 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
    chk("pair_tx_start", 32'(uart_tx), 32'd0);
    chk("pair_gnt0", 32'(gnt), 32'd0);
    repeat (DIV_A * FBITS - 1) @(negedge clk);
    chk("pair_gnt0_end", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("pair_gnt1", 32'(gnt), 32'd1);
    chk("pair_no_gap", 32'(uart_tx), 32'd0);
    repeat (DIV_A * FBITS - 1) @(negedge clk);
    chk("pair_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    chk("pair_busy_end", 32'(busy), 32'd0);
    chk("pair_rises", 32'(rises - r0), 32'(2 * FBITS));
    chk_drained("pair_drained");

    // Overfill FIFO 0 while the line is busy: fifth write dropped
    exp_g.push_back(1'b1); exp_b1.push_back(8'h55);
    wr_one(1'b1, 8'h55);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ovf_rdy0", 32'(rdy0), 32'(i < 4));
      wr0 = 1'b1; din0 = 8'h30 + 8'(i);
      if (i < 4) begin
        exp_g.push_back(1'b0);
        exp_b0.push_back(8'h30 + 8'(i));
      end
    end
    @(negedge clk);
    wr0 = 1'b0;
    chk("ovf_rdy0_full", 32'(rdy0), 32'd0);
    repeat (73) @(negedge clk);
    chk("ovf_rdy0_before_pop", 32'(rdy0), 32'd0);
    @(negedge clk);
    chk("ovf_rdy0_after_pop", 32'(rdy0), 32'd1);
    wait_idle("ovf_idle", 6 * DIV_A * FBITS);
    chk_drained("ovf_drained");

    // Both FIFOs kept full: strict alternation over 12 frames
    do_reset();
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      exp_g.push_back(1'b0);
      exp_g.push_back(1'b1);
    end
    begin
      int n0, n1, guard;
      n0 = 0; n1 = 0; guard = 0;
      while ((n0 < 6 || n1 < 6) && guard < 2000) begin
        @(negedge clk);
        wr0 = 1'b0; wr1 = 1'b0;
        if (n0 < 6 && rdy0) begin
          wr0 = 1'b1; din0 = 8'h60 + 8'(n0);
          exp_b0.push_back(8'h60 + 8'(n0)); n0++;
        end
        if (n1 < 6 && rdy1) begin
          wr1 = 1'b1; din1 = 8'h70 + 8'(n1);
          exp_b1.push_back(8'h70 + 8'(n1)); n1++;
        end
        guard++;
      end
      @(negedge clk);
      wr0 = 1'b0; wr1 = 1'b0;
      chk("fair_writes_done", 32'(guard < 2000), 32'd1);
    end
    wait_idle("fair_idle", 14 * DIV_A * FBITS);
    chk("fair_frames", 32'(frames - f0), 32'd12);
    chk_drained("fair_drained");

    // Reset during DATA bit 4 of a FIFO-1 frame, with FIFO 0 full
    wr_one(1'b1, 8'h07);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr0 = 1'b1; din0 = 8'h90 + 8'(i);
    end
    @(negedge clk);
    wr0 = 1'b0;
    chk("mid_rdy0_full", 32'(rdy0), 32'd0);
    repeat (40) @(negedge clk);
    chk("mid_pre_tx", 32'(uart_tx), 32'd0);
    chk("mid_pre_uclk", 32'(uart_clk), 32'd1);
    chk("mid_pre_gnt", 32'(gnt), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(uart_tx), 32'd1);
    chk("mid_rst_uclk", 32'(uart_clk), 32'd0);
    chk("mid_rst_rdy", {30'd0, rdy1, rdy0}, 32'd3);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_g.delete(); exp_b0.delete(); exp_b1.delete();
    f0 = frames;
    exp_g.push_back(1'b0); exp_b0.push_back(8'h5A);
    wr_one(1'b0, 8'h5A);
    wait_idle("mid_idle", 2 * DIV_A * FBITS);
    chk("mid_frames", 32'(frames - f0), 32'd1);
    chk_drained("mid_drained");

    // DIV=2: push on the cycle of the last-STOP pop keeps the byte
    exp2.push_back(8'hC3); exp2.push_back(8'h3C); exp2.push_back(8'h81);
    @(negedge clk);
    wr0_b = 1'b1; din0_b = 8'hC3;
    @(negedge clk);
    din0_b = 8'h3C;
    @(negedge clk);
    wr0_b = 1'b0;
    repeat (DIV_B * FBITS - 1) @(negedge clk);
    wr0_b = 1'b1; din0_b = 8'h81;
    @(negedge clk);
    wr0_b = 1'b0;
    chk("b_busy_chain", 32'(busy_b), 32'd1);
    begin
      int n;
      n = 0;
      while (busy_b !== 1'b0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("b_idle", 32'(n < 200), 32'd1);
    end
    chk("b_frames", 32'(rx_t.size()), 32'd3);
    if (rx_t.size() == 3) begin
      chk("b_spacing1", 32'(rx_t[1] - rx_t[0]), 32'(DIV_B * FBITS));
      chk("b_spacing2", 32'(rx_t[2] - rx_t[1]), 32'(DIV_B * FBITS));
    end
    chk("b_drained", 32'(exp2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Shared serial-console transmitter for the MC14500 computer. Two byte producers each have a private FIFO: requester 0 is the CPU output latch, requester 1 is the boot/debug monitor. A round-robin scheduler picks one FIFO per frame and serialises the byte onto the clocked `UART_tx`/`UART_clk` pair that the console receiver samples. The block sits between the computer's I/O decode and the top-level UART pins.

## Interface

Parameters:
- `DIV`, default 8: clk cycles per bit period. Must be even and ≥ 2.
- `DEPTH`, default 4: entries per requester FIFO. Must be a power of two and ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state.
- `wr0`  in  1  requester 0 write strobe; accepted only when `rdy0`=1.
- `din0`  in  8  requester 0 byte.
- `rdy0`  out  1  FIFO 0 not full (registered count).
- `wr1`  in  1  requester 1 write strobe; accepted only when `rdy1`=1.
- `din1`  in  8  requester 1 byte.
- `rdy1`  out  1  FIFO 1 not full.
- `busy`  out  1  a frame is in progress, or either FIFO is non-empty.
- `gnt`  out  1  index of the requester whose frame is on the line (or was last sent).
- `UART_tx`  out  1  serial data. Idle level 1.
- `UART_clk`  out  1  bit strobe. Receiver samples on the rising edge. Low when idle.

## Operation

- Frame: 10 bit periods, in this order:
  - start bit 0;
  - data bits d0..d7, LSB first;
  - stop bit 1.
- `UART_clk` pulses exactly once per bit. No pulses are emitted outside frames.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when either FIFO is non-empty. The scheduler pops the selected FIFO into the shift register and records `gnt`.
  - START → DATA after one bit period.
  - DATA → STOP after 8 bit periods. A 3-bit index counts the data bits.
  - STOP → START directly if any FIFO is non-empty (arbitrate and pop in the last STOP cycle). Otherwise STOP → IDLE.
- Arbitration is round-robin.
  - The pointer starts at 0 after reset.
  - If both FIFOs are non-empty, the pointer's FIFO wins. If only one is non-empty, that one wins.
  - After each grant, the pointer becomes the other requester.
- Write-side rules:
  - A write with `rdy`=0 is dropped silently; the count is unchanged.
  - A write and a scheduler pop on the same FIFO in the same cycle is legal: the count is unchanged and the data is preserved.
  - Both requesters may write in the same cycle.
- Width rules:
  - The per-FIFO count is $clog2(DEPTH)+1 bits.
  - FIFO pointers wrap modulo DEPTH.
  - The bit-period counter is $clog2(DIV) bits and wraps at DIV-1.
- Reset values, including reset asserted mid-frame: `UART_tx`=1, `UART_clk`=0, `busy`=0, `gnt`=0, `rdy0`=`rdy1`=1, FSM=IDLE, FIFOs empty. The line returns to idle immediately; a truncated frame is acceptable.

## Timing

- Bit period: DIV cycles.
  - `UART_tx` changes only on the first cycle of a period.
  - `UART_clk` rises at cycle DIV/2 of the period and falls at the period boundary.
- Latency, write to an empty FIFO with the FSM in IDLE:
  - write accepted in cycle t;
  - FIFO non-empty at t+1 (pop decided);
  - `UART_tx`=0 at t+2.
- Back-to-back frames have no idle gap. Each frame is exactly 10·DIV cycles.
- `rdy` deasserts the cycle after the write that fills the FIFO. It reasserts the cycle after the pop.
- `busy` is 0 only in IDLE with both FIFOs empty. It is registered.

## Structure

- Package `uart_sched_pkg` holds:
  - the FSM state enum (IDLE/START/DATA/STOP);
  - `FRAME_BITS`=10;
  - `DATA_BITS`=8.
- Sub-module `uart_sched_fifo`: synchronous FIFO, parameterised on DEPTH, with ports push/din/pop/dout/full/empty. It is instantiated twice. Arbitration, FSM and bit timing stay in the top module.

## Test plan

- Reset, then `wr0` with 0x48 at DIV=8 → `UART_tx` low 2 cycles later; 10 `UART_clk` rises; sampled bits 0,0,0,0,1,0,0,1,0,1; console prints "H"; `busy` falls at frame end.
- Write 0x41 to FIFO 0 and 0x42 to FIFO 1 in the same cycle → frames go out in the order 0x41 then 0x42, back-to-back; `gnt` goes 0 then 1; 20·DIV cycles total.
- Five writes of 0x30..0x34 to FIFO 0 while the line is busy → `rdy0` drops after the 4th stored byte and the 5th write is dropped; line emits 0x30..0x33 only.
- Both FIFOs kept full continuously → strict alternation 0,1,0,1 on `gnt`; no starvation over 8 frames.
- Assert `rst` during DATA bit 4 → `UART_tx`=1 and `UART_clk`=0 asynchronously; `rdy0`=`rdy1`=1; after release, a new write produces a clean frame.
- DIV=2 with write on the same cycle as the last-STOP pop → the new byte is queued, not lost; frame spacing is exactly 20 cycles.
